// File: rtl/dreg_share_arbiter.sv
// Round-robin arbiter sharing one W-bit capture register between N requesters.
// Latency: req -> gnt 1 cycle; granted data -> out/out_valid 1 cycle after each grant cycle.
// Backpressure: owner drops req to end its burst early; bursts cap at MAX_BURST, then one IDLE turnaround.
module dreg_share_arbiter #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4,
  localparam int SW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   out,
  output logic           out_valid,
  output logic [SW-1:0]  out_src,
  output logic           busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [SW-1:0] owner;
  logic [SW-1:0] last_owner;
  logic [3:0]    burst_cnt;

  logic [SW-1:0] pick;
  logic          owner_req;
  logic [W-1:0]  owner_dat;
  logic          burst_last;

  // First set request bit searching upward from the slot after last_owner, wrapping at N.
  function automatic logic [SW-1:0] rr_pick(input logic [N-1:0] r, input logic [SW-1:0] lo);
    logic [SW-1:0] sel;
    logic [SW-1:0] idx;
    logic          found;
    sel   = lo;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = SW'((int'(lo) + k) % N);
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Candidate owner, plus the current owner's request/data and end-of-burst flag.
  always_comb begin
    pick       = rr_pick(req, last_owner);
    owner_req  = req[owner];
    owner_dat  = data[owner*W +: W];
    burst_last = (({1'b0, burst_cnt} + 5'd1) == 5'(MAX_BURST));
  end

  // Arbitration FSM with registered grant, capture register and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= SW'(N - 1);
      burst_cnt  <= '0;
      gnt        <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      out_src    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (|req) begin
            state     <= GRANT;
            owner     <= pick;
            gnt       <= N'(1) << pick;
            busy      <= 1'b1;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (owner_req) begin
            out       <= owner_dat;
            out_src   <= owner;
            out_valid <= 1'b1;
            burst_cnt <= burst_cnt + 4'd1;
            if (burst_last) begin
              state      <= IDLE;
              gnt        <= '0;
              busy       <= 1'b0;
              last_owner <= owner;
            end
          end else begin
            // Owner withdrew: release without capturing; out keeps its old value.
            out_valid  <= 1'b0;
            state      <= IDLE;
            gnt        <= '0;
            busy       <= 1'b0;
            last_owner <= owner;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dreg_share_arbiter.sv
// Self-checking bench for dreg_share_arbiter: vector table, corner sequences, random vs reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stimulus drives req drops and long holds to exercise withdraw and burst cap.
module tb_dreg_share_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic [W-1:0]   out;
  logic           out_valid;
  logic [1:0]     out_src;
  logic           busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dreg_share_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .gnt(gnt),
    .out(out), .out_valid(out_valid), .out_src(out_src), .busy(busy)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        ov;
    logic [7:0]  out;
    logic [1:0]  src;
    logic        busy;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic eov,
                         input logic [7:0] eo, input logic [1:0] es, input logic eb);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
    chk({tag, ".out"}, 32'(out), 32'(eo));
    chk({tag, ".out_src"}, 32'(out_src), 32'(es));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    data  = '0;
    reset = 1'b1;
    #2;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: owner index (-1 when idle), captures in the current burst, last owner.
  int         m_owner, m_caps, m_last, m_src;
  logic [7:0] m_out;
  logic       m_ov;

  task automatic model_reset();
    m_owner = -1; m_caps = 0; m_last = N - 1; m_src = 0; m_out = '0; m_ov = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] d);
    if (m_owner < 0) begin
      m_ov = 1'b0;
      if (r != 0) begin
        for (int j = N; j >= 1; j--)
          if (r[(m_last + j) % N]) m_owner = (m_last + j) % N;
        m_caps = 0;
      end
    end else if (r[m_owner]) begin
      m_out = d[m_owner*W +: W];
      m_src = m_owner;
      m_ov  = 1'b1;
      m_caps++;
      if (m_caps == MB) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else begin
      m_ov    = 1'b0;
      m_last  = m_owner;
      m_owner = -1;
    end
  endtask

  initial begin
    logic [N-1:0] r;

    // Vectors from IDLE with last_owner = 3: short burst, withdraw-on-grant, wrap-around.
    vecs[0]  = '{4'b0100, 32'h00A5_0000, 4'b0100, 1'b0, 8'h00, 2'd0, 1'b1};
    vecs[1]  = '{4'b0100, 32'h00A5_0000, 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1};
    vecs[2]  = '{4'b0100, 32'h005A_0000, 4'b0100, 1'b1, 8'h5A, 2'd2, 1'b1};
    vecs[3]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b0};
    vecs[4]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b0};
    vecs[5]  = '{4'b0001, 32'h0000_00EE, 4'b0001, 1'b0, 8'h5A, 2'd2, 1'b1};
    vecs[6]  = '{4'b0000, 32'h0000_00EE, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b0};
    vecs[7]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b0};
    vecs[8]  = '{4'b1000, 32'h0000_0000, 4'b1000, 1'b0, 8'h5A, 2'd2, 1'b1};
    vecs[9]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b0};
    vecs[10] = '{4'b1001, 32'h0000_0000, 4'b0001, 1'b0, 8'h5A, 2'd2, 1'b1};
    vecs[11] = '{4'b1001, 32'h0000_0011, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1};
    vecs[12] = '{4'b1000, 32'h0000_0011, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b0};
    vecs[13] = '{4'b1000, 32'h0000_0000, 4'b1000, 1'b0, 8'h11, 2'd0, 1'b1};
    vecs[14] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b0};

    // Reset state
    reset = 1'b1; req = '0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      req  = vecs[i].req;
      data = vecs[i].data;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ov, vecs[i].out, vecs[i].src, vecs[i].busy);
    end

    // Reset asserted between edges in the middle of a burst
    do_reset();
    req = 4'b0001; data = 32'h0000_0077;
    repeat (3) tick();
    chk_all("midburst_pre", 4'b0001, 1'b1, 8'h77, 2'd0, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk_all("midburst_rst", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_all("midburst_regrant", 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1);

    // Burst cap: req[1] held continuously
    do_reset();
    req = 4'b0010;
    tick();
    chk_all("cap_grant", 4'b0010, 1'b0, 8'h00, 2'd0, 1'b1);
    for (int k = 0; k < MB; k++) begin
      data[15:8] = 8'h30 + 8'(k);
      tick();
      chk(($sformatf("cap_ov%0d", k)), 32'(out_valid), 32'd1);
      chk(($sformatf("cap_out%0d", k)), 32'(out), 32'(8'h30 + 8'(k)));
      chk(($sformatf("cap_src%0d", k)), 32'(out_src), 32'd1);
    end
    chk("cap_release_gnt", 32'(gnt), 32'd0);
    chk("cap_release_busy", 32'(busy), 32'd0);
    tick();
    chk_all("cap_regrant", 4'b0010, 1'b0, 8'h33, 2'd1, 1'b1);
    data[15:8] = 8'h99;
    tick();
    chk_all("cap_next", 4'b0010, 1'b1, 8'h99, 2'd1, 1'b1);

    // Round-robin fairness with all requesters active
    do_reset();
    req = 4'b1111; data = 32'h0302_0100;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk($sformatf("rr_gnt%0d", g), 32'(gnt), 32'(4'b0001 << (g % 4)));
      for (int c = 0; c < MB; c++) begin
        tick();
        chk($sformatf("rr_out%0d_%0d", g, c), 32'(out), 32'(g % 4));
        chk($sformatf("rr_ov%0d_%0d", g, c), 32'(out_valid), 32'd1);
      end
      chk($sformatf("rr_gap%0d", g), 32'(gnt), 32'd0);
    end

    // Randomized stimulus against the reference model
    do_reset();
    model_reset();
    r = '0;
    for (int t = 0; t < 800; t++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 15) == 0) r = '1;
      req  = r;
      data = N*W'($urandom());
      model_step(req, data);
      tick();
      chk_all($sformatf("rand%0d", t),
              (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner),
              m_ov, m_out, 2'(m_src), (m_owner >= 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dreg_share_arbiter.md
Name: dreg_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one W-bit D-register stage between N requesters.
- Grants one requester at a time and captures its data into the shared output register on each granted cycle.
- Bursts are capped at MAX_BURST captures, so no requester can starve the others.
- Sits in front of the downstream register consumer and replaces per-source D registers.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, data width per requester.
- MAX_BURST, 4, maximum captures per grant (1..15).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  request per requester; bit i belongs to requester i.
- data  input  N*W  requester i data occupies bits [i*W +: W].
- gnt  output  N  one-hot grant, registered.
- out  output  W  shared captured data register.
- out_valid  output  1  high for one cycle after each capture.
- out_src  output  clog2(N) (min 1)  index of the requester whose data is in out.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - state=IDLE, gnt=0, out=0, out_valid=0, out_src=0, busy=0.
  - burst_cnt=0, last_owner=N-1, so requester 0 has first priority.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick owner = the first set req bit searching last_owner+1, last_owner+2, ... modulo N (wraps N-1 -> 0).
  - Next cycle: state=GRANT, gnt=onehot(owner), busy=1, burst_cnt=0.
  - No capture occurs in IDLE.
- GRANT, each cycle, evaluated on req[owner] sampled that cycle:
  - req[owner]=1 (capture): next edge out<=data[owner], out_src<=owner, out_valid<=1, burst_cnt++.
    - If burst_cnt+1==MAX_BURST, next state=IDLE, gnt<=0, last_owner<=owner.
  - req[owner]=0 (owner withdrew): no capture, out_valid<=0, next state=IDLE, gnt<=0, last_owner<=owner.
- out_valid is 0 in every cycle not preceded by a capture.
- out holds its last value until the next capture.
- Latency:
  - First capture: req rises to gnt is 1 cycle, and out/out_valid become valid 1 cycle after the gnt cycle.
  - Every grant ends with at least one IDLE cycle before the next grant. This turnaround gap is intentional.
- Requests from non-owners during GRANT are ignored and do not affect the current burst.
- gnt is never multi-hot and is 0 in IDLE.
- Requesters must hold data stable while gnt[i]=1.
- Simultaneous requests: the rotating priority resolves them; no fixed-priority bias after the first arbitration.

Test Plan:
- Reset mid-burst: req=4'b0001 for 3 cycles, then assert reset asynchronously between edges -> gnt=0, out=0, out_valid=0, busy=0 immediately; after release with req=4'b0001, gnt=4'b0001 again.
- Single requester, short: req[2] high for 2 GRANT cycles with data[2]=8'hA5 then 8'h5A, then drops -> gnt=4'b0100 for 3 cycles; out sequence A5, 5A with out_src=2 and out_valid high 2 cycles; return to IDLE.
- Burst cap: req[1] held high continuously, MAX_BURST=4 -> exactly 4 captures, gnt drops for 1 IDLE cycle, then gnt=4'b0010 re-granted.
- Round-robin fairness: req=4'b1111 held, each requester's data = its index -> grants in order 0,1,2,3,0; each gives 4 captures with out values 0,0,0,0,1,1,1,1,...
- Wrap-around: last_owner=3, req=4'b1001 -> next gnt=4'b0001; after that burst, gnt=4'b1000.
- Withdraw on grant: req[0] pulses 1 cycle only -> gnt=4'b0001 for one cycle, no capture, out_valid stays 0, out unchanged.
